// File: rtl/riscvmc_controller_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle RV32I controller.
// The controller connects through the master modport; the datapath (or a bench) uses the slave modport.
interface riscvmc_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       Retire;
  logic       Illegal;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUControl, Retire, Illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUControl, Retire, Illegal
  );
endinterface

// File: rtl/riscvmc_controller.sv
// Multicycle control FSM for an RV32I core sharing one ALU and one unified memory port.
// Outputs are decoded from the current state; write strobes are held low while reset is high.
//
// state    | meaning
// ---------+----------------------------------------------------------
// FETCH    | read instruction at PC, load IR/OldPC, PC <= PC+4
// DECODE   | read registers, ALUOut <= OldPC+imm (branch/jal target)
// MEMADR   | ALUOut <= rs1+imm for lw/sw
// MEMREAD  | read memory at ALUOut
// MEMWB    | rd <= loaded data
// MEMWRITE | write rs2 to memory at ALUOut
// EXECR    | register-register ALU operation
// EXECI    | register-immediate ALU operation
// ALUWB    | rd <= ALUOut
// BRANCH   | compare rs1/rs2, PC <= target when taken
// JAL      | PC <= target, ALUOut <= OldPC+4
// JALR     | PC <= rs1+imm
// LINKWB   | rd <= OldPC+4
// LUI      | rd <= immediate
// AUIPC    | ALUOut <= OldPC+imm
// TRAP     | unsupported instruction, held until reset
module riscvmc_controller (
  input  logic                 clk,
  input  logic                 reset,
  riscvmc_controller_if.master bus
);
  localparam logic [3:0] RESET_STATE = 4'd0;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    LINKWB   = 4'd12,
    LUI      = 4'd13,
    AUIPC    = 4'd14,
    TRAP     = 4'd15
  } state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= state_t'(RESET_STATE);
    end else begin
      case (state)
        FETCH:    state <= DECODE;
        DECODE: begin
          case (bus.op)
            OP_LOAD, OP_STORE: state <= MEMADR;
            OP_REG:            state <= EXECR;
            OP_IMM:            state <= EXECI;
            OP_BR:             state <= (bus.funct3[2:1] == 2'b00) ? BRANCH : TRAP;
            OP_JAL:            state <= JAL;
            OP_JALR:           state <= JALR;
            OP_LUI:            state <= LUI;
            OP_AUIPC:          state <= AUIPC;
            default:           state <= TRAP;
          endcase
        end
        MEMADR:   state <= bus.op[5] ? MEMWRITE : MEMREAD;
        MEMREAD:  state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: state <= FETCH;
        EXECR:    state <= ALUWB;
        EXECI:    state <= ALUWB;
        ALUWB:    state <= FETCH;
        BRANCH:   state <= FETCH;
        JAL:      state <= ALUWB;
        JALR:     state <= LINKWB;
        LINKWB:   state <= FETCH;
        LUI:      state <= FETCH;
        AUIPC:    state <= ALUWB;
        TRAP:     state <= TRAP;
        default:  state <= TRAP;
      endcase
    end
  end

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire, illegal;
  logic [1:0] result_src, src_a, src_b, alu_op;

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    alu_op     = 2'b00;
    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        src_b      = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
      end
      MEMADR: begin
        src_a = 2'b10;
        src_b = 2'b01;
      end
      MEMREAD: adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = 1'b1;
      end
      EXECR: begin
        src_a  = 2'b10;
        alu_op = 2'b10;
      end
      EXECI: begin
        src_a  = 2'b10;
        src_b  = 2'b01;
        alu_op = 2'b10;
      end
      ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      // only funct3 000 (beq) and 001 (bne) reach this state
      BRANCH: begin
        src_a    = 2'b10;
        alu_op   = 2'b01;
        retire   = 1'b1;
        pc_write = bus.Zero ^ bus.funct3[0];
      end
      JAL: begin
        pc_write = 1'b1;
        src_a    = 2'b01;
        src_b    = 2'b10;
      end
      JALR: begin
        src_a      = 2'b10;
        src_b      = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      LINKWB: begin
        src_a      = 2'b01;
        src_b      = 2'b10;
        result_src = 2'b10;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      LUI: begin
        result_src = 2'b11;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      AUIPC: begin
        src_a = 2'b01;
        src_b = 2'b01;
      end
      TRAP: illegal = 1'b1;
      default: ;
    endcase
  end

  logic [3:0] alu_ctl;

  always_comb begin
    alu_ctl = 4'b0000;
    if (alu_op == 2'b01) begin
      alu_ctl = 4'b0001;
    end else if (alu_op == 2'b10) begin
      case (bus.funct3)
        3'b000: alu_ctl = (bus.op == OP_REG && bus.funct7b5) ? 4'b0001 : 4'b0000;
        3'b001: alu_ctl = 4'b0110;
        3'b010: alu_ctl = 4'b0101;
        3'b011: alu_ctl = 4'b1001;
        3'b100: alu_ctl = 4'b0100;
        3'b101: alu_ctl = bus.funct7b5 ? 4'b1000 : 4'b0111;
        3'b110: alu_ctl = 4'b0011;
        default: alu_ctl = 4'b0010;
      endcase
    end
  end

  logic [2:0] imm_src;

  always_comb begin
    case (bus.op)
      OP_STORE:          imm_src = 3'b001;
      OP_BR:             imm_src = 3'b010;
      OP_JAL:            imm_src = 3'b011;
      OP_LUI, OP_AUIPC:  imm_src = 3'b100;
      default:           imm_src = 3'b000;
    endcase
  end

  assign bus.PCWrite    = pc_write  & ~reset;
  assign bus.MemWrite   = mem_write & ~reset;
  assign bus.IRWrite    = ir_write  & ~reset;
  assign bus.RegWrite   = reg_write & ~reset;
  assign bus.Retire     = retire    & ~reset;
  assign bus.Illegal    = illegal   & ~reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ImmSrc     = imm_src;
  assign bus.ALUControl = alu_ctl;
endmodule
